jstk_poll_scheduler: RTL and testbench

JSTK_POLL_SCHEDULER -- requirements
Module: jstk_poll_scheduler

---
 rtl/jstk_poll_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_jstk_poll_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jstk_poll_scheduler.sv
// jstk_poll_scheduler
// Periodically polls a joystick over an external byte-wide SPI engine.
// A free-running period counter issues a tick every PERIOD cycles while EN
// is high. Each accepted tick runs one frame of five byte exchanges:
//   - SS is lowered.
//   - After SETUP cycles the command byte is sent, then four dummy bytes.
//   - After every byte there is a GAP-cycle pause.
// When the frame completes, the position and button fields are published.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   EN                  enables the period counter (ticks)
//   LED_CMD[1:0]        LED bits carried in the command byte
//   SS                  active-low slave select
//   SPI_START           one-cycle request for one byte exchange
//   SPI_TXBYTE[7:0]     byte to send, valid while SPI_START is high
//   SPI_DONE            one-cycle end-of-exchange pulse from the engine
//   SPI_RXBYTE[7:0]     received byte, valid while SPI_DONE is high
//   X_OUT, Y_OUT[9:0]   last published positions
//   BTN[2:0]            last published button state
//   SAMPLE_VALID        one-cycle pulse aligned with updated outputs
//   OVERRUN             sticky: a tick arrived while a frame was running
//   TIMEOUT_ERR         sticky: a frame was aborted waiting for SPI_DONE
module jstk_poll_scheduler #(
  parameter int PERIOD  = 20000000,
  parameter int SETUP   = 1500,
  parameter int GAP     = 1000,
  parameter int TIMEOUT = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [1:0] LED_CMD,
  output logic       SS,
  output logic       SPI_START,
  output logic [7:0] SPI_TXBYTE,
  input  logic       SPI_DONE,
  input  logic [7:0] SPI_RXBYTE,
  output logic [9:0] X_OUT,
  output logic [9:0] Y_OUT,
  output logic [2:0] BTN,
  output logic       SAMPLE_VALID,
  output logic       OVERRUN,
  output logic       TIMEOUT_ERR
);

  localparam int PW   = $clog2(PERIOD);
  localparam int WMAX = (SETUP > GAP) ? ((SETUP > TIMEOUT) ? SETUP : TIMEOUT)
                                      : ((GAP > TIMEOUT) ? GAP : TIMEOUT);
  localparam int WW   = $clog2(WMAX + 1);

  localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD - 1);
  localparam logic [WW-1:0] SETUP_LAST   = WW'(SETUP - 1);
  localparam logic [WW-1:0] GAP_LAST     = WW'(GAP - 1);
  localparam logic [WW-1:0] TIMEOUT_LAST = WW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP_W   = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP_W     = 3'd4;
  localparam logic [2:0] S_PUBLISH   = 3'd5;

  logic [PW-1:0] period_q, period_d;
  logic [2:0]    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    frame_q [5];
  logic [7:0]    frame_d [5];
  logic          ss_q, ss_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [2:0]    btn_q, btn_d;
  logic          sv_q, sv_d;
  logic          ovr_q, ovr_d;
  logic          terr_q, terr_d;
  logic          tick;

  // The counter is pinned at zero while disabled, so the first tick after
  // enabling lands exactly PERIOD cycles later.
  assign tick = EN && (period_q == PERIOD_LAST);

  always_comb begin
    period_d = period_q;
    if (!EN || tick) begin
      period_d = '0;
    end else begin
      period_d = period_q + 1'b1;
    end
  end

  // Frame sequencer. The single wait counter is shared by the setup, gap and
  // timeout intervals because only one of them is ever active.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    ss_d    = ss_q;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    sv_d    = 1'b0;
    terr_d  = terr_q;
    // Any tick not consumed by IDLE is dropped. This includes a tick in the
    // PUBLISH cycle.
    ovr_d   = ovr_q | (tick && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_SETUP_W;
          ss_d    = 1'b0;
          idx_d   = 3'd0;
          wait_d  = '0;
        end
      end
      S_SETUP_W: begin
        if (wait_q == SETUP_LAST) begin
          state_d = S_START;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_START: begin
        state_d = S_WAIT_DONE;
        wait_d  = '0;
      end
      S_WAIT_DONE: begin
        // A DONE on the final allowed cycle still wins over the timeout.
        if (SPI_DONE) begin
          frame_d[idx_q] = SPI_RXBYTE;
          state_d        = S_GAP_W;
          wait_d         = '0;
        end else if (wait_q == TIMEOUT_LAST) begin
          terr_d  = 1'b1;
          ss_d    = 1'b1;
          state_d = S_IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_GAP_W: begin
        if (wait_q == GAP_LAST) begin
          wait_d = '0;
          if (idx_q < 3'd4) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_PUBLISH;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_PUBLISH: begin
        // Outputs and SAMPLE_VALID change on the same edge that releases SS.
        ss_d    = 1'b1;
        x_d     = {frame_q[1][1:0], frame_q[0]};
        y_d     = {frame_q[3][1:0], frame_q[2]};
        btn_d   = frame_q[4][2:0];
        sv_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        ss_d    = 1'b1;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      period_q <= '0;
      state_q  <= S_IDLE;
      wait_q   <= '0;
      idx_q    <= 3'd0;
      frame_q  <= '{default: 8'h00};
      ss_q     <= 1'b1;
      x_q      <= 10'd0;
      y_q      <= 10'd0;
      btn_q    <= 3'd0;
      sv_q     <= 1'b0;
      ovr_q    <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      state_q  <= state_d;
      wait_q   <= wait_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      ss_q     <= ss_d;
      x_q      <= x_d;
      y_q      <= y_d;
      btn_q    <= btn_d;
      sv_q     <= sv_d;
      ovr_q    <= ovr_d;
      terr_q   <= terr_d;
    end
  end

  // The START state is exactly one cycle long, so decoding it directly gives
  // the single-cycle request. LED_CMD is taken live during byte 0's START.
  assign SPI_START    = (state_q == S_START);
  assign SPI_TXBYTE   = (state_q == S_START && idx_q == 3'd0) ? {6'b100000, LED_CMD} : 8'h00;
  assign SS           = ss_q;
  assign X_OUT        = x_q;
  assign Y_OUT        = y_q;
  assign BTN          = btn_q;
  assign SAMPLE_VALID = sv_q;
  assign OVERRUN      = ovr_q;
  assign TIMEOUT_ERR  = terr_q;

endmodule

// File: tb/tb_jstk_poll_scheduler.sv
// tb_jstk_poll_scheduler
// Directed bench for jstk_poll_scheduler.
//   dut  (PERIOD=200): normal frame, command byte, timeout, reset, EN drop.
//   dut2 (PERIOD=30):  overrun behaviour.
// Each instance has a simple SPI engine model. The model answers DONE four
// cycles after START, and the received bytes come from a table.
module tb_jstk_poll_scheduler;

  localparam int PERIOD  = 200;
  localparam int SETUP   = 3;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       en2 = 1'b0;
  logic [1:0] led = 2'b00;

  logic       ss, spi_start, sv, ovr, terr;
  logic       spi_done = 1'b0;
  logic [7:0] spi_tx;
  logic [7:0] spi_rx = 8'h00;
  logic [9:0] x_out, y_out;
  logic [2:0] btn;

  logic       ss2, start2, sv2, ovr2, terr2;
  logic       done2 = 1'b0;
  logic [7:0] tx2;
  logic [9:0] x2, y2;
  logic [2:0] btn2;

  jstk_poll_scheduler #(.PERIOD(PERIOD), .SETUP(SETUP), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .CLK(clk), .RST(rst), .EN(en), .LED_CMD(led),
    .SS(ss), .SPI_START(spi_start), .SPI_TXBYTE(spi_tx),
    .SPI_DONE(spi_done), .SPI_RXBYTE(spi_rx),
    .X_OUT(x_out), .Y_OUT(y_out), .BTN(btn),
    .SAMPLE_VALID(sv), .OVERRUN(ovr), .TIMEOUT_ERR(terr)
  );

  jstk_poll_scheduler #(.PERIOD(30), .SETUP(SETUP), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut2 (
    .CLK(clk), .RST(rst), .EN(en2), .LED_CMD(2'b00),
    .SS(ss2), .SPI_START(start2), .SPI_TXBYTE(tx2),
    .SPI_DONE(done2), .SPI_RXBYTE(8'h00),
    .X_OUT(x2), .Y_OUT(y2), .BTN(btn2),
    .SAMPLE_VALID(sv2), .OVERRUN(ovr2), .TIMEOUT_ERR(terr2)
  );

  int checks = 0;
  int errors = 0;

  // SPI model and monitor state for dut
  logic [7:0] rx_tab [5];
  logic [7:0] tx_log [5];
  int start_cyc [5];
  int withhold_idx = 9;
  int cyc = 0;
  int pend = 0;
  int pend_idx = 0;
  int byte_idx = 0;
  int start_count = 0;
  int sv_count = 0;
  int ss_run = 0;
  int last_ss_low = 0;
  int terr_cyc = 0;
  logic terr_prev = 1'b0;

  // Model for dut: DONE is raised on the fourth negedge after START is seen,
  // so the DUT samples it at the end of the fourth cycle after START.
  always @(negedge clk) begin
    cyc = cyc + 1;
    spi_done = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0 && pend_idx != withhold_idx) begin
        spi_done = 1'b1;
        spi_rx   = rx_tab[pend_idx];
      end
    end
    if (ss) byte_idx = 0;
    if (spi_start && byte_idx < 5) begin
      pend = 4;
      pend_idx = byte_idx;
      tx_log[byte_idx] = spi_tx;
      start_cyc[byte_idx] = cyc;
      byte_idx = byte_idx + 1;
    end
    if (spi_start) start_count = start_count + 1;
    if (sv) sv_count = sv_count + 1;
    if (terr && !terr_prev) terr_cyc = cyc;
    terr_prev = terr;
    if (!ss) begin
      ss_run = ss_run + 1;
    end else if (ss_run != 0) begin
      last_ss_low = ss_run;
      ss_run = 0;
    end
  end

  int pend2 = 0;
  int start2_count = 0;
  int sv2_count = 0;
  int ss2_run = 0;
  int ss2_rises = 0;
  int ss2_bad = 0;

  // Model for dut2: same latency, always answers zero bytes.
  always @(negedge clk) begin
    done2 = 1'b0;
    if (pend2 > 0) begin
      pend2 = pend2 - 1;
      if (pend2 == 0) done2 = 1'b1;
    end
    if (start2) begin
      pend2 = 4;
      start2_count = start2_count + 1;
    end
    if (sv2) sv2_count = sv2_count + 1;
    if (!ss2) begin
      ss2_run = ss2_run + 1;
    end else if (ss2_run != 0) begin
      if (ss2_run != 39) ss2_bad = ss2_bad + 1;
      ss2_rises = ss2_rises + 1;
      ss2_run = 0;
    end
  end

  // Single comparison point: counts the check and reports any difference.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for SAMPLE_VALID, bounded; a missing pulse is a failed check.
  task automatic wait_sv(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge clk);
      if (sv) seen = 1'b1;
    end
    check_output(tag, 32'(seen), 32'd1);
  endtask

  // Counts negedges until SS is seen low; returns -1 if it never falls.
  task automatic wait_ss_fall(output int n);
    n = -1;
    for (int k = 1; k <= 1000 && n < 0; k++) begin
      @(negedge clk);
      if (!ss) n = k;
    end
  endtask

  // Waits until the model has seen the given number of byte starts in the
  // current frame.
  task automatic wait_byte(input int b, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 600 && !seen; k++) begin
      @(negedge clk);
      if (byte_idx == b) seen = 1'b1;
    end
    check_output(tag, 32'(seen), 32'd1);
  endtask

  int n_fall;
  int sv_before;
  int starts_before;
  bit seen_terr;

  initial begin
    rx_tab = '{8'h34, 8'h02, 8'h78, 8'h01, 8'h05};

    // Reset values
    repeat (3) @(negedge clk);
    check_output("rst_ss", 32'(ss), 32'd1);
    check_output("rst_start", 32'(spi_start), 32'd0);
    check_output("rst_tx", 32'(spi_tx), 32'h00);
    check_output("rst_x", 32'(x_out), 32'd0);
    check_output("rst_y", 32'(y_out), 32'd0);
    check_output("rst_btn", 32'(btn), 32'd0);
    check_output("rst_sv", 32'(sv), 32'd0);
    check_output("rst_ovr", 32'(ovr), 32'd0);
    check_output("rst_terr", 32'(terr), 32'd0);
    rst = 1'b0;

    // Frame A: normal frame, command byte with LED=11
    led = 2'b11;
    @(negedge clk);
    en = 1'b1;
    wait_ss_fall(n_fall);
    check_output("first_tick_delay", 32'(n_fall), 32'd200);
    wait_sv("sv_frame_a");
    check_output("a_x", 32'(x_out), 32'h234);
    check_output("a_y", 32'(y_out), 32'h178);
    check_output("a_btn", 32'(btn), 32'd5);
    check_output("a_ss_high", 32'(ss), 32'd1);
    @(negedge clk);
    check_output("a_sv_one_cycle", 32'(sv), 32'd0);
    @(negedge clk);
    check_output("a_sv_count", 32'(sv_count), 32'd1);
    check_output("a_ss_low_len", 32'(last_ss_low), 32'd39);
    check_output("a_tx0", 32'(tx_log[0]), 32'h83);
    check_output("a_tx1", 32'(tx_log[1]), 32'h00);
    check_output("a_tx2", 32'(tx_log[2]), 32'h00);
    check_output("a_tx3", 32'(tx_log[3]), 32'h00);
    check_output("a_tx4", 32'(tx_log[4]), 32'h00);
    check_output("a_ovr", 32'(ovr), 32'd0);
    check_output("a_terr", 32'(terr), 32'd0);

    // Frame B: LED=01 changes only the command byte
    led = 2'b01;
    wait_sv("sv_frame_b");
    check_output("b_x", 32'(x_out), 32'h234);
    @(negedge clk);
    check_output("b_tx0", 32'(tx_log[0]), 32'h81);
    check_output("b_sv_count", 32'(sv_count), 32'd2);

    // Frame C: DONE withheld on byte 2
    rx_tab = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    withhold_idx = 2;
    seen_terr = 1'b0;
    for (int k = 0; k < 600 && !seen_terr; k++) begin
      @(negedge clk);
      if (terr) seen_terr = 1'b1;
    end
    check_output("c_terr_seen", 32'(seen_terr), 32'd1);
    check_output("c_ss_released", 32'(ss), 32'd1);
    check_output("c_x_held", 32'(x_out), 32'h234);
    check_output("c_y_held", 32'(y_out), 32'h178);
    check_output("c_btn_held", 32'(btn), 32'd5);
    repeat (2) @(negedge clk);
    check_output("c_timeout_len", 32'(terr_cyc - start_cyc[2]), 32'd21);
    check_output("c_no_sv", 32'(sv_count), 32'd2);

    // Frame D: next tick runs a fresh frame
    withhold_idx = 9;
    rx_tab = '{8'h11, 8'h03, 8'h22, 8'h00, 8'h07};
    wait_sv("sv_frame_d");
    check_output("d_x", 32'(x_out), 32'h311);
    check_output("d_y", 32'(y_out), 32'h022);
    check_output("d_btn", 32'(btn), 32'd7);
    check_output("d_terr_sticky", 32'(terr), 32'd1);
    check_output("d_ovr", 32'(ovr), 32'd0);

    // Frame E: reset asserted during byte 3
    wait_byte(4, "e_byte3_reached");
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_output("e_ss", 32'(ss), 32'd1);
    check_output("e_x", 32'(x_out), 32'd0);
    check_output("e_y", 32'(y_out), 32'd0);
    check_output("e_btn", 32'(btn), 32'd0);
    check_output("e_sv", 32'(sv), 32'd0);
    check_output("e_terr", 32'(terr), 32'd0);
    check_output("e_start", 32'(spi_start), 32'd0);
    sv_before = sv_count;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ss_fall(n_fall);
    check_output("f_resume_delay", 32'(n_fall), 32'd200);
    check_output("e_no_sv", 32'(sv_count), 32'(sv_before));

    // Frame F: polling resumed after reset
    wait_sv("sv_frame_f");
    check_output("f_x", 32'(x_out), 32'h311);
    repeat (2) @(negedge clk);
    check_output("f_ss_low_len", 32'(last_ss_low), 32'd39);

    // Frame G: EN dropped during byte 1; the frame still publishes
    rx_tab = '{8'h9A, 8'h01, 8'hBC, 8'h03, 8'h02};
    wait_byte(2, "g_byte1_reached");
    en = 1'b0;
    wait_sv("sv_frame_g");
    check_output("g_x", 32'(x_out), 32'h19A);
    check_output("g_y", 32'(y_out), 32'h3BC);
    check_output("g_btn", 32'(btn), 32'd2);
    @(negedge clk);
    starts_before = start_count;
    repeat (3 * PERIOD) @(negedge clk);
    check_output("g_no_more_starts", 32'(start_count), 32'(starts_before));
    check_output("g_ss_idle", 32'(ss), 32'd1);

    // Overrun instance (PERIOD=30, frame length 39)
    @(negedge clk);
    en2 = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 29) check_output("ovr_ss_before_tick", 32'(ss2), 32'd1);
      if (k == 30) check_output("ovr_ss_first_tick", 32'(ss2), 32'd0);
      if (k == 59) check_output("ovr_flag_before", 32'(ovr2), 32'd0);
      if (k == 60) check_output("ovr_flag_second_tick", 32'(ovr2), 32'd1);
    end
    check_output("ovr_sv_count", 32'(sv2_count), 32'd3);
    check_output("ovr_start_count", 32'(start2_count), 32'd15);
    check_output("ovr_ss_rises", 32'(ss2_rises), 32'd3);
    check_output("ovr_bad_frames", 32'(ss2_bad), 32'd0);
    check_output("ovr_terr", 32'(terr2), 32'd0);

    $display("[TB] directed sequence complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
